// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (baud divider + frame FSM); parity frame bit via `UART_TX_PARITY_EN.
// Latency: start bit on tx one cycle after the tx_valid&tx_ready edge; tx_ready only in IDLE, extra tx_valid is dropped.
module uart_tx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_param: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic parity_q, parity_d;
`endif

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Counter held at zero so the first bit period starts exactly at the transfer edge.
        cnt_d = '0;
        if (tx_valid) begin
          state_d = S_START;
          shift_d = tx_data;
          idx_d   = '0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = (^tx_data) ^ PAR_SENSE;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
`endif
      S_STOP: begin
        // Bit index is reused to count stop-bit periods.
        if (tick) begin
          if (idx_q == STOP_LAST) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: expected per-cycle line state is built from the frame layout of each accepted word.
module tb_uart_tx_param;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 2;
  localparam int PO  = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready, tx, tx_busy, tx_done;

  always #5 clock = ~clock;

  uart_tx_param #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB),
    .PARITY_ODD  (PO)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  typedef struct packed {
    logic line;
    logic busy;
    logic done;
    logic rdy;
  } exp_t;

  localparam exp_t IDLE_E = '{line: 1'b1, busy: 1'b0, done: 1'b0, rdy: 1'b1};

  exp_t exp_q[$];
  exp_t cur = IDLE_E;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  // One accepted word becomes: start, data LSB first, optional parity, stop bits,
  // each held CPB cycles, followed by a single idle cycle carrying the done pulse.
  task automatic push_frame(input logic [DW-1:0] d);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^d) ^ (PO != 0));
`endif
    for (int s = 0; s < SB; s++) bits.push_back(1'b1);
    foreach (bits[k]) begin
      e = '{line: bits[k], busy: 1'b1, done: 1'b0, rdy: 1'b0};
      for (int c = 0; c < CPB; c++) exp_q.push_back(e);
    end
    exp_q.push_back('{line: 1'b1, busy: 1'b0, done: 1'b1, rdy: 1'b1});
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    if (reset) begin
      exp_q.delete();
      cur = IDLE_E;
    end else begin
      if (tx_valid && cur.rdy) push_frame(tx_data);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = IDLE_E;
    end
    #1;
    check("tx",    32'(tx),       32'(cur.line));
    check("busy",  32'(tx_busy),  32'(cur.busy));
    check("done",  32'(tx_done),  32'(cur.done));
    check("ready", 32'(tx_ready), 32'(cur.rdy));
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single 0xA5 frame, then idle past its end
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (60) step();

    // Valid held high with data changed mid-frame; next word taken at the first idle cycle
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) tx_data = 8'hFF;
      step();
    end
    tx_valid = 1'b0;
    repeat (60) step();

    // One-cycle reset 15 cycles into a frame, then a fresh frame
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (14) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    tx_data  = 8'h5E;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (60) step();

    // Random traffic: bursty valid, data churning while busy, rare resets
    for (int i = 0; i < 3000; i++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = DW'($urandom);
      reset    = ($urandom_range(0, 249) == 0);
      step();
    end
    reset    = 1'b0;
    tx_valid = 1'b0;
    repeat (60) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
